// File: rtl/mux_seq_pkg.sv
// mux_seq_pkg -- shared types and constants for the select-mux driver stage.
//   sel_e        : select state code, value is {s1, s0} driven to the mux
//   SYNC_STAGES  : depth of every input synchroniser
//   DEF_*        : default timing for a 100 MHz board clock
package mux_seq_pkg;

  typedef enum logic [1:0] {
    SEL_U = 2'b00,
    SEL_V = 2'b01,
    SEL_W = 2'b10
  } sel_e;

  localparam int SYNC_STAGES    = 2;

  localparam int DEF_DEB_CYCLES = 1000000;    // 10 ms
  localparam int DEF_DEB_W      = 20;
  localparam int DEF_AUTO_DIV   = 100000000;  // 1 s
  localparam int DEF_AUTO_W     = 27;

endpackage

// File: rtl/mux_sel_sequencer_btn_debounce.sv
// btn_debounce -- synchroniser, debounce counter and rising-edge strobe for
// one bouncy push button.
//   clk, rst  : system clock, asynchronous active-high reset
//   btn_raw   : raw button, asynchronous to clk
//   btn_rise  : one-cycle strobe on the cycle after the debounced level rises
// Parameters: DEB_CYCLES (stable cycles needed for a level change), DEB_W
// (counter width, 2^DEB_W > DEB_CYCLES).
module btn_debounce
  import mux_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DEB_W      = DEF_DEB_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic [DEB_W-1:0]       cnt;
  logic                   lvl;
  logic                   lvl_d;
  logic                   btn_s;

  assign btn_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn_raw};
      lvl_d <= lvl;
      // Any cycle of agreement restarts the count, so a bounce never
      // accumulates across glitches.
      if (btn_s == lvl) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        lvl <= ~lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign btn_rise = lvl & ~lvl_d;

endmodule

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer -- upstream driver for the two-level select mux.
// Synchronises the board switches into u/v/w, steps the select code
// U -> V -> W -> U on a debounced button press or an auto-cycle timer, and
// produces the golden mux result exp_m.
//   clk, rst            : system clock, asynchronous active-high reset
//   sw_u/sw_v/sw_w      : raw data switches
//   btn_step            : raw step button (bouncy)
//   auto_en             : raw switch, 1 = step from the auto timer
//   m_in                : downstream mux output (self-check only)
//   u, v, w             : synchronised data to the mux
//   s0, s1, sel_state   : registered select code
//   step_pulse          : high for the cycle in which the select changed
//   exp_m               : golden mux output
//   chk_err             : sticky m_in vs exp_m mismatch
// Build option: define SELF_CHECK_EN to build the m_in compare; otherwise
// m_in is ignored and chk_err is constant 0.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int DEB_W      = DEF_DEB_W,
  parameter int AUTO_DIV   = DEF_AUTO_DIV,
  parameter int AUTO_W     = DEF_AUTO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_u,
  input  logic       sw_v,
  input  logic       sw_w,
  input  logic       btn_step,
  input  logic       auto_en,
  input  logic       m_in,
  output logic       u,
  output logic       v,
  output logic       w,
  output logic       s0,
  output logic       s1,
  output logic [1:0] sel_state,
  output logic       step_pulse,
  output logic       exp_m,
  output logic       chk_err
);

  localparam int NUM_SW = 4;

  // switch synchronisers: index 0..3 = u, v, w, auto_en
  logic [NUM_SW-1:0]                  sw_raw;
  logic [NUM_SW-1:0][SYNC_STAGES-1:0] sw_sync;
  logic                               auto_en_s;

  assign sw_raw = {auto_en, sw_w, sw_v, sw_u};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync <= '0;
    end else begin
      for (int i = 0; i < NUM_SW; i++)
        sw_sync[i] <= {sw_sync[i][SYNC_STAGES-2:0], sw_raw[i]};
    end
  end

  assign u         = sw_sync[0][SYNC_STAGES-1];
  assign v         = sw_sync[1][SYNC_STAGES-1];
  assign w         = sw_sync[2][SYNC_STAGES-1];
  assign auto_en_s = sw_sync[3][SYNC_STAGES-1];

  // button path
  logic btn_rise;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_step),
    .btn_rise (btn_rise)
  );

  // auto tick: held at 0 in button mode so the first auto step lands a full
  // AUTO_DIV cycles after auto mode is entered
  logic [AUTO_W-1:0] tick;
  logic              auto_wrap;
  logic              step;

  assign auto_wrap = auto_en_s & (tick == AUTO_W'(AUTO_DIV - 1));
  assign step      = auto_en_s ? auto_wrap : btn_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            tick <= '0;
    else if (!auto_en_s) tick <= '0;
    else if (auto_wrap) tick <= '0;
    else                tick <= tick + 1'b1;
  end

  // select FSM
  sel_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEL_U;
      step_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_pulse <= step;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEL_U:   if (step) state_d = SEL_V;
      SEL_V:   if (step) state_d = SEL_W;
      SEL_W:   if (step) state_d = SEL_U;
      default: state_d = SEL_U;  // illegal 2'b11 recovers unconditionally
    endcase
  end

  always_comb begin
    sel_state = state_q;
    s0        = state_q[0];
    s1        = state_q[1];
  end

  assign exp_m = s1 ? w : (s0 ? v : u);

`ifdef SELF_CHECK_EN
  // The mux output is allowed to settle for the step cycle and the one after.
  logic step_pulse_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_pulse_d <= 1'b0;
      chk_err      <= 1'b0;
    end else begin
      step_pulse_d <= step_pulse;
      if (!step_pulse && !step_pulse_d && (m_in != exp_m))
        chk_err <= 1'b1;
    end
  end
`else
  logic unused_m_in;
  assign unused_m_in = m_in;
  assign chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb_mux_sel_sequencer -- scoreboard bench for mux_sel_sequencer with
// DEB_CYCLES = 4 and AUTO_DIV = 8. Stimulus pushes each expected select
// step (cycle and new code) into a queue; the monitor pops one entry per
// step_pulse and compares. Direct checks cover reset, data path and chk_err.
module tb_mux_sel_sequencer;

  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;
  localparam int AUTO_DIV   = 8;
  localparam int AUTO_W     = 4;
  // button press at cycle k -> select changes on edge k + 2 sync + 4 deb + 1
  localparam int BTN_LAT    = 7;

`ifdef SELF_CHECK_EN
  localparam logic EXP_CHK = 1'b1;
`else
  localparam logic EXP_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_u = 1'b0, sw_v = 1'b0, sw_w = 1'b0;
  logic       btn_step = 1'b0, auto_en = 1'b0;
  logic       inj = 1'b0;
  logic       m_in;
  logic       u, v, w, s0, s1, step_pulse, exp_m, chk_err;
  logic [1:0] sel_state;

  mux_sel_sequencer #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W),
    .AUTO_DIV   (AUTO_DIV),
    .AUTO_W     (AUTO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_u       (sw_u),
    .sw_v       (sw_v),
    .sw_w       (sw_w),
    .btn_step   (btn_step),
    .auto_en    (auto_en),
    .m_in       (m_in),
    .u          (u),
    .v          (v),
    .w          (w),
    .s0         (s0),
    .s1         (s1),
    .sel_state  (sel_state),
    .step_pulse (step_pulse),
    .exp_m      (exp_m),
    .chk_err    (chk_err)
  );

  // downstream mux stand-in, with a fault injector
  assign m_in = exp_m ^ inj;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] sel;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [1:0] mdl_sel = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic expect_step(input int at);
    mdl_sel = nxt(mdl_sel);
    q.push_back('{at: at, sel: mdl_sel});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: hold the button 8 cycles, then release and let the
  // debounced level fall again.
  task automatic press(input bit counts);
    if (counts) expect_step(cyc + BTN_LAT);
    btn_step = 1'b1;
    tick(8);
    btn_step = 1'b0;
    tick(12);
  endtask

  // monitor
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && step_pulse) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL extra_step: step_pulse with sel %b, none expected (cycle %0d)", sel_state, cyc);
      end else begin
        e = q.pop_front();
        chk("step_cycle", cyc, e.at);
        chk("step_sel_state", sel_state, e.sel);
        chk("step_s1s0", {s1, s0}, e.sel);
      end
    end
  end

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_chk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    tick(2);
    chk("reset_sel_state", sel_state, 2'b00);
    chk("reset_outs", {u, v, w, s0, s1, step_pulse, exp_m, chk_err}, 8'h00);
    rst = 1'b0;
    sw_u = 1'b1;
    tick(3);
    chk("u_after_sync", u, 1'b1);
    chk("exp_m_sel_u", exp_m, 1'b1);

    // bounce: 2-cycle pulses never reach 4 stable cycles
    btn_step = 1'b1; tick(2);
    btn_step = 1'b0; tick(2);
    btn_step = 1'b1; tick(2);
    btn_step = 1'b0; tick(10);
    chk("bounce_no_step", sel_state, 2'b00);
    press(1'b1);                       // -> V

    // reset mid-press: immediate clear, then a full re-qualification
    btn_step = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    chk("midrun_rst_sel", sel_state, 2'b00);
    chk("midrun_rst_outs", {u, v, w, s0, s1, step_pulse, exp_m, chk_err}, 8'h00);
    mdl_sel = 2'b00;
    tick(2);
    rst = 1'b0;
    expect_step(cyc + BTN_LAT);        // held button, counted from release
    tick(1);
    chk("rst_release_sel", sel_state, 2'b00);
    tick(7);
    btn_step = 1'b0;
    tick(12);

    // wrap-around from reset: 01, 10, 00, 01
    rst = 1'b1; tick(1); rst = 1'b0;
    mdl_sel = 2'b00;
    tick(2);
    repeat (4) press(1'b1);

    // auto mode for 40 cycles; first step 2 sync + 8 cycles later
    begin
      int k;
      k = cyc;
      auto_en = 1'b1;
      for (int i = 0; i < 5; i++) expect_step(k + 2 + AUTO_DIV * (i + 1));
      tick(3);
      press(1'b0);                     // ignored in auto mode
      tick(17);
      auto_en = 1'b0;
      tick(10);
    end

    // data path at SEL_W
    press(1'b1);
    press(1'b1);
    chk("at_sel_w", sel_state, 2'b10);
    chk("exp_m_w0", exp_m, 1'b0);
    sw_w = 1'b1;
    tick(1);
    chk("w_lat1", w, 1'b0);
    tick(1);
    chk("w_lat2", w, 1'b1);
    chk("exp_m_w1", exp_m, 1'b1);
    sw_u = 1'b0; sw_v = 1'b1;
    tick(3);
    chk("u_follows", u, 1'b0);
    chk("exp_m_ignores_uv", exp_m, 1'b1);

    // self-check: mismatch in a quiet cycle
    inj = 1'b1; tick(1); inj = 1'b0;
    tick(1);
    chk("chk_err_set", chk_err, EXP_CHK);
    tick(5);
    chk("chk_err_sticky", chk_err, EXP_CHK);
    rst = 1'b1; #1;
    chk("chk_err_rst", chk_err, 1'b0);
    mdl_sel = 2'b00;
    tick(1); rst = 1'b0; tick(2);

    // mismatch only on the step_pulse cycle is masked
    expect_step(cyc + BTN_LAT);
    btn_step = 1'b1;
    tick(7);
    chk("pulse_cycle", step_pulse, 1'b1);
    inj = 1'b1; tick(1); inj = 1'b0;
    btn_step = 1'b0;
    tick(12);
    chk("chk_err_masked", chk_err, 1'b0);

    chk("queue_drained", q.size(), 0);
    summary();
    $finish;
  end

endmodule
